rob_commit: RTL and testbench

// - In-order reorder buffer behind rename. Accepts renamed ops (tag, rd_new_p, rd_old_p),

---
 rtl/rob_commit.sv | 171 +++++++++++++++++
 tb/tb_rob_commit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// In-order reorder buffer: dispatch, writeback, in-order retire, branch squash.
// Define ROB_EXC_EN to add writeback exceptions that flush the whole buffer.
module rob_commit #(
  parameter int N_PHYS    = 64,
  parameter int ROB_TAG_W = 6,
  localparam int PW = $clog2(N_PHYS),
  localparam int TW = ROB_TAG_W,
  localparam int D  = 2**ROB_TAG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_valid_i,
  output logic          disp_ready_o,
  input  logic [TW-1:0] disp_tag_i,
  input  logic          disp_rd_used_i,
  input  logic [4:0]    disp_rd_arch_i,
  input  logic [PW-1:0] disp_rd_new_p_i,
  input  logic [PW-1:0] disp_rd_old_p_i,
  input  logic          wb_valid_i,
  input  logic [TW-1:0] wb_tag_i,
  input  logic          recover_i,
  input  logic [TW-1:0] recover_tag_i,
  output logic          commit_valid_o,
  output logic [TW-1:0] commit_tag_o,
  output logic [4:0]    commit_rd_arch_o,
  output logic [PW-1:0] commit_rd_p_o,
  output logic          free_valid_o,
  output logic [PW-1:0] free_preg_o,
  output logic [TW:0]   count_o,
  output logic          empty_o,
  output logic          full_o,
`ifdef ROB_EXC_EN
  input  logic          wb_exc_i,
  output logic          exc_valid_o,
  output logic [TW-1:0] exc_tag_o,
`endif
  output logic          tag_err_o
);

  logic [TW-1:0] head, tail;
  logic [TW:0]   count, count_nxt;
  logic [D-1:0]  valid, valid_nxt;
  logic [D-1:0]  done, done_nxt;
  logic [D-1:0]  squash;
  logic [D-1:0]  used;
  logic [4:0]    arch  [D];
  logic [PW-1:0] new_p [D];
  logic [PW-1:0] old_p [D];

  logic accept, com, exc_now;
  logic rec_ok, rec_err, wb_drop, wb_set, wb_err;
  logic [TW-1:0] rec_age;

  function automatic logic [TW-1:0] rel(input logic [TW-1:0] t,
                                        input logic [TW-1:0] h);
    return t - h;
  endfunction

`ifdef ROB_EXC_EN
  logic [D-1:0] exc, exc_nxt;
  assign exc_now = valid[head] && done[head] && exc[head];
  assign disp_ready_o = !full_o && !recover_i && !exc_now;
`else
  assign exc_now = 1'b0;
  assign disp_ready_o = !full_o && !recover_i;
`endif

  assign count_o = count;
  assign empty_o = (count == '0);
  assign full_o  = (count == (TW+1)'(D));

  assign accept  = disp_valid_i && disp_ready_o;
  assign com     = valid[head] && done[head] && !exc_now;
  assign rec_ok  = recover_i && valid[recover_tag_i] && !exc_now;
  assign rec_err = recover_i && !valid[recover_tag_i];
  assign rec_age = rel(recover_tag_i, head);
  assign wb_drop = rec_ok && (rel(wb_tag_i, head) > rec_age);
  assign wb_err  = wb_valid_i && !valid[wb_tag_i];
  assign wb_set  = wb_valid_i && valid[wb_tag_i] && !wb_drop && !exc_now;

  // Age is measured from head so squash works across the wrap point.
  always_comb begin
    squash = '0;
    for (int i = 0; i < D; i++)
      squash[i] = rec_ok && (rel(TW'(i), head) > rec_age);
  end

  always_comb begin
    valid_nxt = valid;
    if (com) valid_nxt[head] = 1'b0;
    valid_nxt = valid_nxt & ~squash;
    if (accept) valid_nxt[tail] = 1'b1;
    if (exc_now) valid_nxt = '0;
  end

  always_comb begin
    done_nxt = done;
    if (accept) done_nxt[tail] = 1'b0;
    if (wb_set) done_nxt[wb_tag_i] = 1'b1;
  end

`ifdef ROB_EXC_EN
  always_comb begin
    exc_nxt = exc;
    if (accept) exc_nxt[tail] = 1'b0;
    if (wb_set) exc_nxt[wb_tag_i] = wb_exc_i;
  end
`endif

  always_comb begin
    count_nxt = count + {{TW{1'b0}}, accept} - {{TW{1'b0}}, com};
    if (rec_ok)
      count_nxt = {1'b0, rec_age} + (TW+1)'(1) - {{TW{1'b0}}, com};
    if (exc_now)
      count_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      valid            <= '0;
      done             <= '0;
      commit_valid_o   <= 1'b0;
      commit_tag_o     <= '0;
      commit_rd_arch_o <= '0;
      commit_rd_p_o    <= '0;
      free_valid_o     <= 1'b0;
      free_preg_o      <= '0;
      tag_err_o        <= 1'b0;
`ifdef ROB_EXC_EN
      exc              <= '0;
      exc_valid_o      <= 1'b0;
      exc_tag_o        <= '0;
`endif
    end else begin
      valid            <= valid_nxt;
      done             <= done_nxt;
      count            <= count_nxt;
      commit_valid_o   <= com;
      commit_tag_o     <= com ? head : '0;
      commit_rd_arch_o <= com ? arch[head] : '0;
      commit_rd_p_o    <= com ? new_p[head] : '0;
      free_valid_o     <= com && used[head] && (old_p[head] != '0);
      free_preg_o      <= (com && used[head]) ? old_p[head] : '0;
      if (com) head <= head + TW'(1);
      if (rec_ok) tail <= recover_tag_i + TW'(1);
      else if (accept) tail <= tail + TW'(1);
      if ((accept && disp_tag_i != tail) || wb_err || rec_err)
        tag_err_o <= 1'b1;
`ifdef ROB_EXC_EN
      exc         <= exc_nxt;
      exc_valid_o <= exc_now;
      exc_tag_o   <= exc_now ? head : '0;
      if (exc_now) tail <= head;
`endif
    end
  end

  // Payload needs no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (accept) begin
      used[tail]  <= disp_rd_used_i;
      arch[tail]  <= disp_rd_arch_i;
      new_p[tail] <= disp_rd_new_p_i;
      old_p[tail] <= disp_rd_old_p_i;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: vector table plus multi-cycle sequences.
module tb_rob_commit;

  logic       clk = 1'b0;
  logic       rst;
  logic       disp_valid_i;
  logic       disp_ready_o;
  logic [5:0] disp_tag_i;
  logic       disp_rd_used_i;
  logic [4:0] disp_rd_arch_i;
  logic [5:0] disp_rd_new_p_i;
  logic [5:0] disp_rd_old_p_i;
  logic       wb_valid_i;
  logic [5:0] wb_tag_i;
  logic       recover_i;
  logic [5:0] recover_tag_i;
  logic       commit_valid_o;
  logic [5:0] commit_tag_o;
  logic [4:0] commit_rd_arch_o;
  logic [5:0] commit_rd_p_o;
  logic       free_valid_o;
  logic [5:0] free_preg_o;
  logic [6:0] count_o;
  logic       empty_o;
  logic       full_o;
  logic       tag_err_o;
`ifdef ROB_EXC_EN
  logic       wb_exc_i;
  logic       exc_valid_o;
  logic [5:0] exc_tag_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rob_commit #(.N_PHYS(64), .ROB_TAG_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .disp_valid_i(disp_valid_i),
    .disp_ready_o(disp_ready_o),
    .disp_tag_i(disp_tag_i),
    .disp_rd_used_i(disp_rd_used_i),
    .disp_rd_arch_i(disp_rd_arch_i),
    .disp_rd_new_p_i(disp_rd_new_p_i),
    .disp_rd_old_p_i(disp_rd_old_p_i),
    .wb_valid_i(wb_valid_i),
    .wb_tag_i(wb_tag_i),
    .recover_i(recover_i),
    .recover_tag_i(recover_tag_i),
    .commit_valid_o(commit_valid_o),
    .commit_tag_o(commit_tag_o),
    .commit_rd_arch_o(commit_rd_arch_o),
    .commit_rd_p_o(commit_rd_p_o),
    .free_valid_o(free_valid_o),
    .free_preg_o(free_preg_o),
    .count_o(count_o),
    .empty_o(empty_o),
    .full_o(full_o),
`ifdef ROB_EXC_EN
    .wb_exc_i(wb_exc_i),
    .exc_valid_o(exc_valid_o),
    .exc_tag_o(exc_tag_o),
`endif
    .tag_err_o(tag_err_o)
  );

  typedef struct {
    bit       dv;
    bit [5:0] dt;
    bit       du;
    bit [4:0] da;
    bit [5:0] dn;
    bit [5:0] dold;
    bit       wv;
    bit [5:0] wt;
    bit       cv;
    bit [5:0] ct;
    bit [4:0] ca;
    bit [5:0] cp;
    bit       fv;
    bit [5:0] fp;
    bit [6:0] cnt;
    bit       err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    disp_valid_i    = 1'b0;
    disp_tag_i      = '0;
    disp_rd_used_i  = 1'b0;
    disp_rd_arch_i  = '0;
    disp_rd_new_p_i = '0;
    disp_rd_old_p_i = '0;
    wb_valid_i      = 1'b0;
    wb_tag_i        = '0;
    recover_i       = 1'b0;
    recover_tag_i   = '0;
`ifdef ROB_EXC_EN
    wb_exc_i        = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic disp(input logic [5:0] t);
    idle();
    disp_valid_i    = 1'b1;
    disp_tag_i      = t;
    disp_rd_used_i  = 1'b1;
    disp_rd_arch_i  = 5'(t) + 5'd1;
    disp_rd_new_p_i = t;
    disp_rd_old_p_i = 6'd1;
    tick();
  endtask

  task automatic wb(input logic [5:0] t);
    idle();
    wb_valid_i = 1'b1;
    wb_tag_i   = t;
    tick();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_commit", commit_valid_o, 0);
    chk("rst_free", free_valid_o, 0);
    chk("rst_err", tag_err_o, 0);
    chk("rst_ready", disp_ready_o, 1);
    rst = 1'b0;

    //            dv dt du da dn  dold wv wt cv ct ca cp  fv fp cnt err
    vq.push_back('{1, 0, 1, 3, 40, 5,  0, 0, 0, 0, 0, 0,  0, 0, 1, 0});
    vq.push_back('{0, 0, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0,  0, 0, 1, 0});
    vq.push_back('{0, 0, 0, 0, 0,  0,  0, 0, 1, 0, 3, 40, 1, 5, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0});
    vq.push_back('{1, 1, 1, 1, 41, 6,  0, 0, 0, 0, 0, 0,  0, 0, 1, 0});
    vq.push_back('{1, 2, 1, 2, 42, 0,  0, 0, 0, 0, 0, 0,  0, 0, 2, 0});
    vq.push_back('{1, 3, 0, 0, 43, 7,  0, 0, 0, 0, 0, 0,  0, 0, 3, 0});
    vq.push_back('{0, 0, 0, 0, 0,  0,  1, 3, 0, 0, 0, 0,  0, 0, 3, 0});
    vq.push_back('{0, 0, 0, 0, 0,  0,  1, 2, 0, 0, 0, 0,  0, 0, 3, 0});
    vq.push_back('{0, 0, 0, 0, 0,  0,  1, 1, 0, 0, 0, 0,  0, 0, 3, 0});
    vq.push_back('{0, 0, 0, 0, 0,  0,  0, 0, 1, 1, 1, 41, 1, 6, 2, 0});
    vq.push_back('{0, 0, 0, 0, 0,  0,  0, 0, 1, 2, 2, 42, 0, 0, 1, 0});
    vq.push_back('{0, 0, 0, 0, 0,  0,  0, 0, 1, 3, 0, 43, 0, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0});
    vq.push_back('{1, 4, 1, 4, 44, 8,  0, 0, 0, 0, 0, 0,  0, 0, 1, 0});
    vq.push_back('{1, 5, 1, 5, 45, 9,  1, 4, 0, 0, 0, 0,  0, 0, 2, 0});
    vq.push_back('{1, 6, 1, 6, 46, 10, 0, 0, 1, 4, 4, 44, 1, 8, 2, 0});
    vq.push_back('{0, 0, 0, 0, 0,  0,  1, 9, 0, 0, 0, 0,  0, 0, 2, 1});

    for (int i = 0; i < vq.size(); i++) begin
      idle();
      disp_valid_i    = vq[i].dv;
      disp_tag_i      = vq[i].dt;
      disp_rd_used_i  = vq[i].du;
      disp_rd_arch_i  = vq[i].da;
      disp_rd_new_p_i = vq[i].dn;
      disp_rd_old_p_i = vq[i].dold;
      wb_valid_i      = vq[i].wv;
      wb_tag_i        = vq[i].wt;
      tick();
      chk($sformatf("v%0d_cv", i), commit_valid_o, vq[i].cv);
      chk($sformatf("v%0d_ct", i), commit_tag_o, vq[i].ct);
      chk($sformatf("v%0d_ca", i), commit_rd_arch_o, vq[i].ca);
      chk($sformatf("v%0d_cp", i), commit_rd_p_o, vq[i].cp);
      chk($sformatf("v%0d_fv", i), free_valid_o, vq[i].fv);
      chk($sformatf("v%0d_fp", i), free_preg_o, vq[i].fp);
      chk($sformatf("v%0d_cnt", i), count_o, vq[i].cnt);
      chk($sformatf("v%0d_err", i), tag_err_o, vq[i].err);
    end

    // Fill to full, retire one, wrap tail to tag 0.
    do_reset();
    for (int t = 0; t < 64; t++) disp(6'(t));
    chk("full_count", count_o, 64);
    chk("full_flag", full_o, 1);
    chk("full_ready", disp_ready_o, 0);
    disp(6'd5);
    chk("full_block_cnt", count_o, 64);
    chk("full_block_err", tag_err_o, 0);
    wb(6'd0);
    idle();
    tick();
    chk("full_commit", commit_valid_o, 1);
    chk("full_commit_tag", commit_tag_o, 0);
    chk("full_cnt63", count_o, 63);
    chk("full_ready_back", disp_ready_o, 1);
    disp(6'd0);
    chk("wrap_count", count_o, 64);
    chk("wrap_err", tag_err_o, 0);
    chk("wrap_full", full_o, 1);

    // Recover squashes tags 3..5.
    do_reset();
    for (int t = 0; t < 6; t++) disp(6'(t));
    idle();
    recover_i       = 1'b1;
    recover_tag_i   = 6'd2;
    disp_valid_i    = 1'b1;
    disp_tag_i      = 6'd6;
    #1;
    chk("rec_ready", disp_ready_o, 0);
    tick();
    chk("rec_count", count_o, 3);
    disp(6'd3);
    chk("rec_disp_cnt", count_o, 4);
    chk("rec_tail3", tag_err_o, 0);
    wb(6'd4);
    chk("rec_wb_sq_err", tag_err_o, 1);
    disp(6'd4);
    chk("err_sticky", tag_err_o, 1);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_cnt", count_o, 0);
    chk("midrst_err", tag_err_o, 0);
    chk("midrst_empty", empty_o, 1);

    // Recover in the same cycle the head retires.
    for (int t = 0; t < 3; t++) disp(6'(t));
    wb(6'd0);
    idle();
    recover_i     = 1'b1;
    recover_tag_i = 6'd1;
    tick();
    chk("reccom_cv", commit_valid_o, 1);
    chk("reccom_tag", commit_tag_o, 0);
    chk("reccom_cnt", count_o, 1);
    disp(6'd2);
    chk("reccom_tail", tag_err_o, 0);
    chk("reccom_cnt2", count_o, 2);
    idle();
    recover_i     = 1'b1;
    recover_tag_i = 6'd40;
    tick();
    chk("badrec_err", tag_err_o, 1);
    chk("badrec_cnt", count_o, 2);

`ifdef ROB_EXC_EN
    do_reset();
    disp(6'd0);
    disp(6'd1);
    idle();
    wb_valid_i = 1'b1;
    wb_tag_i   = 6'd0;
    wb_exc_i   = 1'b1;
    tick();
    idle();
    tick();
    chk("exc_valid", exc_valid_o, 1);
    chk("exc_tag", exc_tag_o, 0);
    chk("exc_nocommit", commit_valid_o, 0);
    chk("exc_nofree", free_valid_o, 0);
    chk("exc_count", count_o, 0);
    tick();
    chk("exc_pulse", exc_valid_o, 0);
    disp(6'd0);
    chk("exc_tail", tag_err_o, 0);
    chk("exc_cnt1", count_o, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
